core_ifetch: RTL and testbench

//  Instruction-fetch stage of the multi-cycle RV32I core; sits directly upstream of the decode stage.

---
 rtl/core_ifetch_pkg.sv | 8 +
 rtl/core_ifetch.sv | 80 ++++++++
 tb/tb_core_ifetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/core_ifetch_pkg.sv
// core_ifetch_pkg: shared constants for the instruction-fetch stage
package core_ifetch_pkg;
  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_ADDR = 2'd1;
  localparam logic [1:0] FETCH_DATA = 2'd2;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
endpackage

// File: rtl/core_ifetch.sv
// core_ifetch: holds the PC and fetches one instruction word per controller request
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        C_FETCH,
  input  logic        PC_WE,
  input  logic [31:0] PC_IN,
  output logic [31:0] PC,
  output logic [31:0] IMEM_ARADDR,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  input  logic [31:0] IMEM_RDATA,
  input  logic [1:0]  IMEM_RRESP,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  output logic [31:0] INSTRUCTION,
  output logic        FETCH_DONE,
  output logic        FETCH_ERR
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic [31:0] fetch_addr;
  logic expire;
  assign fetch_addr = PC_WE ? PC_IN : PC;
  assign expire = timer == TW'(TIMEOUT_CYCLES - 1);
  // completion is tested before expiry so a response on the last allowed cycle still succeeds
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH_IDLE;
      timer <= '0;
      PC <= RESET_VECTOR;
      IMEM_ARADDR <= RESET_VECTOR;
      IMEM_ARVALID <= 1'b0;
      IMEM_RREADY <= 1'b0;
      INSTRUCTION <= INSTR_NOP;
      FETCH_DONE <= 1'b0;
      FETCH_ERR <= 1'b0;
    end else begin
      FETCH_DONE <= 1'b0;
      FETCH_ERR <= 1'b0;
      if (state == FETCH_IDLE) begin
        if (PC_WE) PC <= PC_IN;
        if (C_FETCH && fetch_addr[1:0] != 2'b00) begin
          FETCH_ERR <= 1'b1;
          INSTRUCTION <= INSTR_NOP;
        end else if (C_FETCH) begin
          state <= FETCH_ADDR;
          IMEM_ARADDR <= fetch_addr;
          IMEM_ARVALID <= 1'b1;
          timer <= '0;
        end
      end else if (state == FETCH_DATA && IMEM_RVALID && IMEM_RREADY) begin
        INSTRUCTION <= IMEM_RRESP == RRESP_OKAY ? IMEM_RDATA : INSTR_NOP;
        FETCH_DONE <= IMEM_RRESP == RRESP_OKAY;
        FETCH_ERR <= IMEM_RRESP != RRESP_OKAY;
        IMEM_RREADY <= 1'b0;
        state <= FETCH_IDLE;
      end else if (expire) begin
        FETCH_ERR <= 1'b1;
        INSTRUCTION <= INSTR_NOP;
        IMEM_ARVALID <= 1'b0;
        IMEM_RREADY <= 1'b0;
        state <= FETCH_IDLE;
      end else begin
        timer <= timer + 1'b1;
        if (state == FETCH_ADDR && IMEM_ARVALID && IMEM_ARREADY) begin
          IMEM_ARVALID <= 1'b0;
          IMEM_RREADY <= 1'b1;
          state <= FETCH_DATA;
        end
      end
    end
  end
endmodule

// File: tb/tb_core_ifetch.sv
// tb_core_ifetch: directed spot checks plus randomized traffic against a transaction-level model
module tb_core_ifetch;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int TO = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, c_fetch = 0, pc_we = 0, arready = 0, rvalid = 0;
  logic [31:0] pc_in = 0, rdata = 0;
  logic [1:0] rresp = 0;
  logic [31:0] pc, araddr, instruction;
  logic arvalid, rready, fetch_done, fetch_err;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [31:0] m_pc, m_instr, m_addr;
  bit m_busy, m_granted, m_done, m_err;
  int m_age;

  core_ifetch #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst), .C_FETCH(c_fetch), .PC_WE(pc_we), .PC_IN(pc_in), .PC(pc),
    .IMEM_ARADDR(araddr), .IMEM_ARVALID(arvalid), .IMEM_ARREADY(arready),
    .IMEM_RDATA(rdata), .IMEM_RRESP(rresp), .IMEM_RVALID(rvalid), .IMEM_RREADY(rready),
    .INSTRUCTION(instruction), .FETCH_DONE(fetch_done), .FETCH_ERR(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // one outstanding request: address issued until granted, then waiting for data, aborted after TO edges
  task automatic model_step();
    m_done = 0;
    m_err = 0;
    if (rst) begin
      m_pc = RV; m_instr = NOP; m_busy = 0; m_granted = 0; m_age = 0;
      return;
    end
    if (!m_busy) begin
      logic [31:0] a;
      a = pc_we ? pc_in : m_pc;
      if (pc_we) m_pc = pc_in;
      if (c_fetch && a % 4 != 0) begin
        m_err = 1; m_instr = NOP;
      end else if (c_fetch) begin
        m_busy = 1; m_addr = a; m_age = 0; m_granted = 0;
      end
    end else if (m_granted && rvalid) begin
      m_busy = 0;
      if (rresp == 2'b00) begin m_done = 1; m_instr = rdata; end
      else begin m_err = 1; m_instr = NOP; end
    end else if (m_age + 1 == TO) begin
      m_busy = 0; m_err = 1; m_instr = NOP;
    end else begin
      if (arready) m_granted = 1;
      m_age++;
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("pc", pc, m_pc);
    chk("instruction", instruction, m_instr);
    chk("fetch_done", 32'(fetch_done), 32'(m_done));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    chk("arvalid", 32'(arvalid), 32'(m_busy && !m_granted));
    chk("rready", 32'(rready), 32'(m_busy && m_granted));
    if (m_busy && !m_granted) chk("araddr", araddr, m_addr);
  end

  // ar_k/rv_k: first cycle offset at which ARREADY/RVALID go (and stay) high, -1 = never
  task automatic scen(input bit we, input logic [31:0] addr, input int ar_k, input int rv_k,
                      input logic [1:0] resp, input logic [31:0] data, input int len,
                      output int done_k, output int err_k, output int err_n, output int arv_n);
    done_k = -1; err_k = -1; err_n = 0; arv_n = 0;
    pc_we = we; pc_in = addr; c_fetch = 1; rresp = resp; rdata = data;
    arready = ar_k == 0; rvalid = rv_k == 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (fetch_done && done_k < 0) done_k = k;
      if (fetch_err) begin err_n++; if (err_k < 0) err_k = k; end
      if (arvalid) arv_n++;
      if (k == 1 && addr[1:0] == 2'b00) chk("araddr_issue", araddr, addr);
      if (k <= ar_k) chk("araddr_hold", araddr, addr);
      pc_we = 0; c_fetch = 0;
      arready = ar_k >= 0 && k >= ar_k;
      rvalid = rv_k >= 0 && k >= rv_k;
    end
    arready = 0; rvalid = 0; rresp = 0;
  endtask

  initial begin
    int dk, ek, en, an, p;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_instr", instruction, 32'h0000_0013);
    chk("reset_arvalid", 32'(arvalid), 32'h0);
    scen(0, 32'h0, 0, 0, 2'b00, 32'h0050_0093, 6, dk, ek, en, an);
    chk("t1_done_cycle", dk, 3);
    chk("t1_instr", instruction, 32'h0050_0093);
    chk("t1_err_count", en, 0);
    scen(1, 32'h100, 5, 8, 2'b00, 32'h00a0_0113, 12, dk, ek, en, an);
    chk("t2_done_cycle", dk, 9);
    chk("t2_pc", pc, 32'h100);
    chk("t2_instr", instruction, 32'h00a0_0113);
    pc_we = 1; pc_in = 32'h400; c_fetch = 1; arready = 1;
    @(negedge clk);
    pc_we = 0; c_fetch = 0;
    @(negedge clk);
    chk("t6_rready_before", 32'(rready), 32'h1);
    rst = 1; rvalid = 1; rdata = 32'hdead_beef;
    @(negedge clk);
    chk("t6_rready", 32'(rready), 32'h0);
    chk("t6_instr", instruction, 32'h0000_0013);
    chk("t6_pc", pc, 32'h0);
    chk("t6_done", 32'(fetch_done | fetch_err), 32'h0);
    rst = 0;
    @(negedge clk);
    chk("t6_no_pulse", 32'(fetch_done | fetch_err), 32'h0);
    rvalid = 0; arready = 0;
    scen(1, 32'h102, 0, 0, 2'b00, 32'h1234_5678, 4, dk, ek, en, an);
    chk("t3_err_cycle", ek, 1);
    chk("t3_err_count", en, 1);
    chk("t3_arvalid_cycles", an, 0);
    chk("t3_instr", instruction, 32'h0000_0013);
    scen(1, 32'h200, 0, 0, 2'b10, 32'h1111_1111, 6, dk, ek, en, an);
    chk("t4_err_cycle", ek, 3);
    chk("t4_err_count", en, 1);
    chk("t4_no_done", dk, -1);
    chk("t4_instr", instruction, 32'h0000_0013);
    scen(1, 32'h300, -1, 0, 2'b00, 32'h2222_2222, 24, dk, ek, en, an);
    chk("t5_err_cycle", ek, 17);
    chk("t5_err_count", en, 1);
    chk("t5_arvalid_cycles", an, 16);
    chk("t5_no_done", dk, -1);
    p = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) p = (i / 250) % 4 == 0 ? 100 : (i / 250) % 4 == 1 ? 50 : (i / 250) % 4 == 2 ? 12 : 3;
      rst = $urandom_range(0, 299) == 0;
      c_fetch = $urandom_range(0, 2) == 0;
      pc_we = $urandom_range(0, 3) == 0;
      pc_in = $urandom & ($urandom_range(0, 7) == 0 ? 32'hffff_ffff : 32'hffff_fffc);
      arready = $urandom_range(0, 99) < p;
      rvalid = $urandom_range(0, 99) < p;
      rdata = $urandom;
      rresp = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
